// File: rtl/hs_rr_merge_arbiter_if.sv
// hs_rr_merge_arbiter_if: source-side and consumer-side handshake bundle for the merge arbiter
interface hs_rr_merge_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int GW = $clog2(NUM_SRC);
    logic [NUM_SRC-1:0]            src_en;
    logic [NUM_SRC-1:0]            src_req;
    logic [NUM_SRC-1:0]            src_ack;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_din;
    logic                          dout_req;
    logic                          dout_ack;
    logic [DATA_WIDTH-1:0]         dout;
    logic [GW-1:0]                 grant;
    logic                          busy;
    logic                          timeout_pulse;
    logic                          stray_pulse;
    modport master (
        input  src_en, src_ack, src_din, dout_req,
        output src_req, dout_ack, dout, grant, busy, timeout_pulse, stray_pulse
    );
    modport slave (
        output src_en, src_ack, src_din, dout_req,
        input  src_req, dout_ack, dout, grant, busy, timeout_pulse, stray_pulse
    );
endinterface

// File: rtl/hs_rr_merge_arbiter.sv
// hs_rr_merge_arbiter: round-robin N-to-1 merge of req/ack token sources with a per-grant fetch timeout
module hs_rr_merge_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input logic clk,
    input logic rst,
    hs_rr_merge_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;
    state_t             state;
    logic [GW-1:0]      ptr, nxt, inc, j;
    logic [TW-1:0]      timer;
    logic [NUM_SRC-1:0] owned;
    logic               tmo;
    // Scan downward so the last hit is the first enabled source at or after ptr
    always_comb begin
        nxt = ptr;
        j = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = GW'((int'(ptr) + k) % NUM_SRC);
            if (bus.src_en[j]) nxt = j;
        end
    end
    assign inc   = (bus.grant == GW'(NUM_SRC - 1)) ? '0 : bus.grant + GW'(1);
    assign owned = (state == FETCH) ? (NUM_SRC'(1) << bus.grant) : '0;
    assign tmo   = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            timer             <= '0;
            bus.src_req       <= '0;
            bus.dout_ack      <= 1'b0;
            bus.dout          <= '0;
            bus.grant         <= '0;
            bus.busy          <= 1'b0;
            bus.timeout_pulse <= 1'b0;
            bus.stray_pulse   <= 1'b0;
        end else begin
            bus.dout_ack      <= 1'b0;
            bus.timeout_pulse <= 1'b0;
            bus.stray_pulse   <= |(bus.src_ack & ~owned);
            case (state)
                IDLE: if (bus.dout_req && |bus.src_en) begin
                    bus.grant   <= nxt;
                    bus.src_req <= NUM_SRC'(1) << nxt;
                    timer       <= '0;
                    bus.busy    <= 1'b1;
                    state       <= FETCH;
                end
                FETCH: if (bus.src_ack[bus.grant]) begin
                    bus.dout    <= bus.src_din[bus.grant*DATA_WIDTH +: DATA_WIDTH];
                    bus.src_req <= '0;
                    state       <= DELIVER;
                end else if (tmo) begin
                    bus.src_req       <= '0;
                    bus.timeout_pulse <= 1'b1;
                    ptr               <= inc;
                    bus.busy          <= 1'b0;
                    state             <= IDLE;
                end else begin
                    timer <= timer + TW'(1);
                end
                DELIVER: if (bus.dout_req) begin
                    bus.dout_ack <= 1'b1;
                    ptr          <= inc;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs_rr_merge_arbiter.sv
// tb_hs_rr_merge_arbiter: scoreboarded producers and consumer exercising fairness, masking, timeout, stall, stray and reset
module tb_hs_rr_merge_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int errors = 0;
    logic [31:0] q[$];
    int dly[4];
    int base[4];
    int cnt[4];
    int wt[4];
    int rnd = 0;
    logic [3:0] stray_inj = '0;
    hs_rr_merge_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(32)) bus();
    hs_rr_merge_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );
    always #5 clk = ~clk;
    // Producers: ack after dly[i] sampled cycles of src_req; every ack pushes its token to the scoreboard
    always @(negedge clk) begin
        logic [3:0] a;
        a = '0;
        for (int i = 0; i < 4; i++) begin
            if (rst || !bus.src_req[i]) wt[i] = 0;
            else if (dly[i] >= 0) begin
                if (wt[i] == dly[i]) begin
                    a[i] = 1'b1;
                    bus.src_din[i*32 +: 32] = 32'(base[i] + cnt[i]);
                    q.push_back(32'(base[i] + cnt[i]));
                    cnt[i]++;
                    wt[i] = 0;
                    if (rnd != 0) dly[i] = int'($urandom_range(0, 3));
                end else wt[i]++;
            end
        end
        bus.src_ack = a | stray_inj;
    end
    // Scoreboard and handshake invariants
    logic [3:0] preq = '0;
    logic pack = 1'b0;
    always @(negedge clk) begin
        logic [31:0] want;
        if (bus.dout_ack) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected dout_ack dout=%0d required=no delivery", bus.dout);
            end else begin
                want = q.pop_front();
                if (bus.dout !== want) begin
                    errors++;
                    $display("FAIL sb_data dout=%0d required=%0d", bus.dout, want);
                end
            end
        end
        vectors++;
        if ($countones(bus.src_req) > 1) begin
            errors++;
            $display("FAIL req_overlap src_req=%b required=onehot or zero", bus.src_req);
        end
        vectors++;
        if (pack && bus.dout_ack) begin
            errors++;
            $display("FAIL ack_consecutive dout_ack=1 required=0 after ack");
        end
        vectors++;
        if (preq != 0 && bus.src_req != 0 && bus.src_req != preq) begin
            errors++;
            $display("FAIL req_switch src_req=%b required=idle gap after %b", bus.src_req, preq);
        end
        preq = bus.src_req;
        pack = bus.dout_ack;
    end
    task automatic do_reset(input logic [3:0] en);
        @(negedge clk);
        rst = 1'b1;
        bus.dout_req = 1'b0;
        bus.src_en = en;
        stray_inj = '0;
        rnd = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            dly[i] = 1;
            base[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask
    task automatic check_zero(input string tag);
        vectors += 7;
        if (bus.src_req !== 4'b0) begin errors++; $display("FAIL %s_src_req got=%b required=0", tag, bus.src_req); end
        if (bus.dout_ack !== 1'b0) begin errors++; $display("FAIL %s_dout_ack got=%b required=0", tag, bus.dout_ack); end
        if (bus.dout !== 32'd0) begin errors++; $display("FAIL %s_dout got=%0d required=0", tag, bus.dout); end
        if (bus.grant !== 2'd0) begin errors++; $display("FAIL %s_grant got=%0d required=0", tag, bus.grant); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy got=%b required=0", tag, bus.busy); end
        if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL %s_timeout got=%b required=0", tag, bus.timeout_pulse); end
        if (bus.stray_pulse !== 1'b0) begin errors++; $display("FAIL %s_stray got=%b required=0", tag, bus.stray_pulse); end
    endtask
    task automatic wait_req0(input string tag);
        for (int c = 0; c < 40 && !bus.src_req[0]; c++) @(negedge clk);
        vectors++;
        if (!bus.src_req[0]) begin errors++; $display("FAIL %s_req_wait src_req=%b required=0001", tag, bus.src_req); end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
    endtask
    task automatic test_fairness;
        int k;
        logic [31:0] want;
        do_reset(4'hf);
        for (int i = 0; i < 4; i++) begin
            base[i] = i * 100;
            dly[i] = int'($urandom_range(0, 3));
        end
        rnd = 1;
        bus.dout_req = 1'b1;
        k = 0;
        for (int c = 0; c < 20000 && k < 400; c++) begin
            @(negedge clk);
            if (bus.dout_ack) begin
                want = 32'((k % 4) * 100 + k / 4);
                vectors++;
                if (bus.dout !== want) begin errors++; $display("FAIL fair_order token=%0d dout=%0d required=%0d", k, bus.dout, want); end
                k++;
            end
        end
        bus.dout_req = 1'b0;
        vectors++;
        if (k != 400) begin errors++; $display("FAIL fair_count tokens=%0d required=400", k); end
    endtask
    task automatic test_masking;
        int n;
        logic [3:0] pr;
        do_reset(4'b0101);
        bus.dout_req = 1'b1;
        n = 0;
        pr = '0;
        for (int c = 0; c < 500 && n < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.src_req[1] || bus.src_req[3]) begin errors++; $display("FAIL mask_disabled src_req=%b required=bits 1,3 low", bus.src_req); end
            if (bus.src_req != 0 && pr == 0) begin
                vectors += 2;
                if (bus.src_req !== ((n % 2) ? 4'b0100 : 4'b0001)) begin errors++; $display("FAIL mask_req n=%0d src_req=%b required=%b", n, bus.src_req, (n % 2) ? 4'b0100 : 4'b0001); end
                if (bus.grant !== ((n % 2) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL mask_grant n=%0d grant=%0d required=%0d", n, bus.grant, (n % 2) ? 2 : 0); end
                n++;
            end
            pr = bus.src_req;
        end
        bus.dout_req = 1'b0;
        vectors++;
        if (n != 8) begin errors++; $display("FAIL mask_count grants=%0d required=8", n); end
    endtask
    task automatic test_timeout;
        int hi, tp;
        logic done;
        do_reset(4'hf);
        dly[1] = -1;
        bus.dout_req = 1'b1;
        hi = 0;
        tp = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (bus.src_req[1]) hi++;
            if (bus.timeout_pulse) tp++;
            if (bus.src_req[2]) begin
                done = 1'b1;
                vectors++;
                if (bus.grant !== 2'd2) begin errors++; $display("FAIL tmo_next_grant grant=%0d required=2", bus.grant); end
            end
        end
        bus.dout_req = 1'b0;
        vectors += 3;
        if (!done) begin errors++; $display("FAIL tmo_wait src_req=%b required=0100 eventually", bus.src_req); end
        if (hi != 16) begin errors++; $display("FAIL tmo_req_cycles got=%0d required=16", hi); end
        if (tp != 1) begin errors++; $display("FAIL tmo_pulses got=%0d required=1", tp); end
    endtask
    task automatic test_stall;
        logic [31:0] held;
        int acks;
        do_reset(4'b0001);
        dly[0] = 2;
        base[0] = 500;
        bus.dout_req = 1'b1;
        wait_req0("stall");
        bus.dout_req = 1'b0;
        for (int c = 0; c < 20 && bus.src_req != 0; c++) @(negedge clk);
        held = bus.dout;
        vectors++;
        if (held !== 32'd500) begin errors++; $display("FAIL stall_capture dout=%0d required=500", held); end
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (bus.dout_ack || bus.src_req != 0 || bus.dout !== held || !bus.busy) begin
                errors++;
                $display("FAIL stall_hold ack=%b req=%b dout=%0d busy=%b required=0,0,%0d,1", bus.dout_ack, bus.src_req, bus.dout, bus.busy, held);
            end
        end
        bus.dout_req = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.dout_ack) begin acks++; bus.dout_req = 1'b0; end
        end
        bus.dout_req = 1'b0;
        vectors++;
        if (acks != 1) begin errors++; $display("FAIL stall_release acks=%0d required=1", acks); end
    endtask
    task automatic test_race_stray;
        int acks, tp;
        do_reset(4'b0001);
        dly[0] = 15;
        base[0] = 700;
        bus.dout_req = 1'b1;
        acks = 0;
        tp = 0;
        for (int c = 0; c < 100 && acks == 0; c++) begin
            @(negedge clk);
            if (bus.timeout_pulse) tp++;
            if (bus.dout_ack) begin
                acks++;
                bus.dout_req = 1'b0;
                vectors++;
                if (bus.dout !== 32'd700) begin errors++; $display("FAIL race_data dout=%0d required=700", bus.dout); end
            end
        end
        bus.dout_req = 1'b0;
        vectors += 2;
        if (acks != 1) begin errors++; $display("FAIL race_ack acks=%0d required=1", acks); end
        if (tp != 0) begin errors++; $display("FAIL race_timeout pulses=%0d required=0", tp); end
        @(posedge clk); #1 stray_inj = 4'b0010;
        @(posedge clk); #1 stray_inj = 4'b0000;
        @(negedge clk);
        vectors += 3;
        if (bus.stray_pulse !== 1'b1) begin errors++; $display("FAIL stray_idle_pulse got=%b required=1", bus.stray_pulse); end
        if (bus.dout_ack !== 1'b0) begin errors++; $display("FAIL stray_idle_ack got=%b required=0", bus.dout_ack); end
        if (bus.src_req !== 4'b0) begin errors++; $display("FAIL stray_idle_req got=%b required=0", bus.src_req); end
        @(negedge clk);
        vectors++;
        if (bus.stray_pulse !== 1'b0) begin errors++; $display("FAIL stray_width got=%b required=0", bus.stray_pulse); end
        dly[0] = 4;
        bus.dout_req = 1'b1;
        wait_req0("stray_fetch");
        @(posedge clk); #1 stray_inj = 4'b0100;
        @(posedge clk); #1 stray_inj = 4'b0000;
        @(negedge clk);
        vectors++;
        if (bus.stray_pulse !== 1'b1) begin errors++; $display("FAIL stray_fetch_pulse got=%b required=1", bus.stray_pulse); end
        for (int c = 0; c < 20 && !bus.dout_ack; c++) @(negedge clk);
        bus.dout_req = 1'b0;
        vectors++;
        if (bus.dout_ack !== 1'b1 || bus.dout !== 32'd701) begin errors++; $display("FAIL stray_fetch_data ack=%b dout=%0d required=1,701", bus.dout_ack, bus.dout); end
    endtask
    task automatic test_reset_mid;
        do_reset(4'b0001);
        dly[0] = 5;
        base[0] = 900;
        bus.dout_req = 1'b1;
        wait_req0("rst_fetch");
        @(negedge clk);
        rst = 1'b1;
        bus.dout_req = 1'b0;
        @(negedge clk);
        check_zero("rst_fetch");
        rst = 1'b0;
        dly[0] = 0;
        bus.dout_req = 1'b1;
        wait_req0("rst_deliver");
        bus.dout_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.src_req !== 4'b0) begin errors++; $display("FAIL rst_deliver_state busy=%b req=%b required=1,0", bus.busy, bus.src_req); end
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_deliver");
        rst = 1'b0;
        q.delete();
        bus.dout_req = 1'b1;
        for (int c = 0; c < 30 && !bus.dout_ack; c++) @(negedge clk);
        bus.dout_req = 1'b0;
        vectors++;
        if (bus.dout_ack !== 1'b1 || bus.dout !== 32'd901) begin errors++; $display("FAIL rst_discard ack=%b dout=%0d required=1,901", bus.dout_ack, bus.dout); end
    endtask
    initial begin
        bus.src_en = '0;
        bus.dout_req = 1'b0;
        bus.src_din = '0;
        for (int i = 0; i < 4; i++) begin
            dly[i] = 1;
            base[i] = 0;
            cnt[i] = 0;
            wt[i] = 0;
        end
        test_reset;
        test_fairness;
        test_masking;
        test_timeout;
        test_stall;
        test_race_stray;
        test_reset_mid;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
